// File: rtl/currctrl_bus_endpoint_if.sv
// Bridge-side register bus of the CurrCTRL endpoint: the request and response signals of one transfer.
interface currctrl_bus_endpoint_if;
    logic [6:0]  bus_address;
    logic        bus_enable;
    logic [3:0]  bus_byte_enable;
    logic        bus_rw;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_acknowledge;
    logic        bus_irq;

    modport master (
        output bus_address, bus_enable, bus_byte_enable, bus_rw, bus_write_data,
        input  bus_read_data, bus_acknowledge, bus_irq
    );

    modport slave (
        input  bus_address, bus_enable, bus_byte_enable, bus_rw, bus_write_data,
        output bus_read_data, bus_acknowledge, bus_irq
    );
endinterface

// File: rtl/currctrl_bus_endpoint.sv
// CurrCTRL register endpoint: double-buffered coil setpoints, current readback, control and fault IRQs.
// Optional setpoint watchdog is compiled in with `define CURRCTRL_WDOG_EN.
module currctrl_bus_endpoint #(
    parameter int NUM_COILS   = 4,
    parameter int SP_W        = 16,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    currctrl_bus_endpoint_if.slave    bus,
    input  logic [NUM_COILS-1:0]      coil_fault,
    input  logic [NUM_COILS*SP_W-1:0] coil_current,
    output logic [NUM_COILS*SP_W-1:0] coil_setpoint,
    output logic                      setpoint_update,
    output logic                      coil_enable
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK, S_RELEASE} state_t;
    typedef logic [NUM_COILS-1:0][SP_W-1:0] sp_arr_t;

    state_t state_q, state_d;
    logic   access;

    logic                 enable_q, enable_d;
    logic                 irq_en_q, irq_en_d;
    logic                 dirty_q,  dirty_d;
    logic                 upd_q,    upd_d;
    logic [NUM_COILS-1:0] pend_q,   pend_d;
    logic [NUM_COILS-1:0] fault_q;
    sp_arr_t              shadow_q, shadow_d;
    sp_arr_t              active_q, active_d;
    logic [31:0]          rdata_q,  rdata_d;
    logic [31:0]          rd_mux;

    logic [4:0]  word;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wr, commit, soft_clr;
    logic        wdog_trip, wdog_fault;

    assign word     = bus.bus_address[6:2];
    assign be       = bus.bus_byte_enable;
    assign wdata    = bus.bus_write_data;
    assign wr       = access & ~bus.bus_rw;
    assign commit   = wr & (word == 5'd3) & be[0] & wdata[0];
    assign soft_clr = wr & (word == 5'd0) & be[0] & wdata[2];

    logic unused_bus;
    assign unused_bus = ^{bus.bus_address[1:0], bus.bus_write_data[31:16], bus.bus_byte_enable[3:2]};

    // Transfer FSM: state register / next state / outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.bus_enable) state_d = S_ACCESS;
            S_ACCESS:  state_d = S_ACK;
            S_ACK:     state_d = S_RELEASE;
            S_RELEASE: if (!bus.bus_enable) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        access              = 1'b0;
        bus.bus_acknowledge = 1'b0;
        case (state_q)
            S_ACCESS: access              = 1'b1;
            S_ACK:    bus.bus_acknowledge = 1'b1;
            default: ;
        endcase
    end

    // Read decode; anything not mapped reads as zero
    always_comb begin
        rd_mux = '0;
        case (word)
            5'd0:    rd_mux[1:0] = {irq_en_q, enable_q};
            5'd1:    rd_mux[1:0] = {dirty_q, wdog_fault};
            5'd2:    rd_mux[NUM_COILS-1:0] = pend_q;
            default: ;
        endcase
        for (int n = 0; n < NUM_COILS; n++) begin
            if (word == 5'(8 + n))  rd_mux[SP_W-1:0] = shadow_q[n];
            if (word == 5'(16 + n)) rd_mux[SP_W-1:0] = coil_current[n*SP_W +: SP_W];
        end
    end

    always_comb begin
        enable_d = enable_q;
        irq_en_d = irq_en_q;
        dirty_d  = dirty_q;
        pend_d   = pend_q;
        shadow_d = shadow_q;
        active_d = active_q;
        upd_d    = 1'b0;
        rdata_d  = rdata_q;

        if (wr && word == 5'd0 && be[0]) begin
            enable_d = wdata[0];
            irq_en_d = wdata[1];
        end
        if (wr && word == 5'd2 && be[0])
            pend_d = pend_q & ~wdata[NUM_COILS-1:0];
        for (int n = 0; n < NUM_COILS; n++) begin
            if (wr && word == 5'(8 + n)) begin
                if (be[0]) shadow_d[n][7:0]  = wdata[7:0];
                if (be[1]) shadow_d[n][15:8] = wdata[15:8];
                dirty_d = 1'b1;
            end
        end
        if (commit) begin
            active_d = shadow_q;
            dirty_d  = 1'b0;
            upd_d    = 1'b1;
        end
        if (wdog_trip) active_d = '0;
        if (soft_clr) begin
            shadow_d = '0;
            active_d = '0;
            pend_d   = '0;
            dirty_d  = 1'b0;
        end
        // A fresh fault edge survives any clear landing in the same cycle
        pend_d = pend_d | (coil_fault & ~fault_q);

        if (access && bus.bus_rw) rdata_d = rd_mux;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            dirty_q  <= 1'b0;
            upd_q    <= 1'b0;
            pend_q   <= '0;
            fault_q  <= '0;
            shadow_q <= '0;
            active_q <= '0;
            rdata_q  <= '0;
        end else begin
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            dirty_q  <= dirty_d;
            upd_q    <= upd_d;
            pend_q   <= pend_d;
            fault_q  <= coil_fault;
            shadow_q <= shadow_d;
            active_q <= active_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef CURRCTRL_WDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_fault_q, wdog_fault_d;

    // Counter saturates at the limit so the trip fires once until cleared
    assign wdog_trip  = enable_q & (wdog_cnt_q == WDOG_MAX) & ~wdog_fault_q & ~commit & ~soft_clr;
    assign wdog_fault = wdog_fault_q;

    always_comb begin
        wdog_cnt_d   = wdog_cnt_q;
        wdog_fault_d = wdog_fault_q;
        if (commit || soft_clr || !enable_q) wdog_cnt_d = '0;
        else if (wdog_cnt_q != WDOG_MAX)     wdog_cnt_d = wdog_cnt_q + 1'b1;
        if (soft_clr)       wdog_fault_d = 1'b0;
        else if (wdog_trip) wdog_fault_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt_q   <= '0;
            wdog_fault_q <= 1'b0;
        end else begin
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_fault_q <= wdog_fault_d;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES != 0);
    assign wdog_trip   = 1'b0;
    assign wdog_fault  = 1'b0;
`endif

    for (genvar g = 0; g < NUM_COILS; g++) begin : g_coil
        assign coil_setpoint[g*SP_W +: SP_W] = (enable_q && !wdog_fault) ? active_q[g] : '0;
    end

    assign coil_enable       = enable_q;
    assign setpoint_update   = upd_q;
    assign bus.bus_read_data = rdata_q;
    assign bus.bus_irq       = (irq_en_q & |pend_q) | wdog_fault;

endmodule

// File: tb/tb_currctrl_bus_endpoint.sv
// Directed and randomized bench for currctrl_bus_endpoint against a register-level model.
module tb_currctrl_bus_endpoint;
    localparam int N = 4;

    logic          clk;
    logic          reset_n;
    logic [N-1:0]  coil_fault;
    logic [N*16-1:0] coil_current;
    logic [N*16-1:0] coil_setpoint;
    logic          setpoint_update;
    logic          coil_enable;

    currctrl_bus_endpoint_if bus_if();

    currctrl_bus_endpoint #(.NUM_COILS(N), .SP_W(16), .WDOG_CYCLES(100)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_if),
        .coil_fault(coil_fault), .coil_current(coil_current),
        .coil_setpoint(coil_setpoint), .setpoint_update(setpoint_update),
        .coil_enable(coil_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // register-level model
    logic [15:0] m_shadow [N];
    logic [15:0] m_active [N];
    logic        m_enable, m_irq_en, m_dirty;
    logic [N-1:0] m_pend;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int n = 0; n < N; n++) begin m_shadow[n] = '0; m_active[n] = '0; end
        m_enable = 0; m_irq_en = 0; m_dirty = 0; m_pend = '0;
    endtask

    task automatic m_write(input logic [6:0] a, input logic [3:0] be, input logic [31:0] d);
        int w;
        w = int'(a[6:2]);
        if (w == 0 && be[0]) begin
            m_enable = d[0]; m_irq_en = d[1];
            if (d[2]) begin
                for (int n = 0; n < N; n++) begin m_shadow[n] = '0; m_active[n] = '0; end
                m_pend = '0; m_dirty = 0;
            end
        end else if (w == 2 && be[0]) begin
            m_pend = m_pend & ~d[N-1:0];
        end else if (w == 3 && be[0] && d[0]) begin
            for (int n = 0; n < N; n++) m_active[n] = m_shadow[n];
            m_dirty = 0;
        end else if (w >= 8 && w < 8 + N) begin
            if (be[0]) m_shadow[w-8][7:0]  = d[7:0];
            if (be[1]) m_shadow[w-8][15:8] = d[15:8];
            m_dirty = 1;
        end
    endtask

    function automatic logic [31:0] m_read(input logic [6:0] a);
        int w;
        w = int'(a[6:2]);
        if (w == 0) return {30'd0, m_irq_en, m_enable};
        if (w == 1) return {30'd0, m_dirty, 1'b0};
        if (w == 2) return {{(32-N){1'b0}}, m_pend};
        if (w >= 8 && w < 8 + N)   return {16'd0, m_shadow[w-8]};
        if (w >= 16 && w < 16 + N) return {16'd0, coil_current[(w-16)*16 +: 16]};
        return 32'd0;
    endfunction

    function automatic logic [63:0] exp_sp();
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < N; n++) r[n*16 +: 16] = m_enable ? m_active[n] : 16'd0;
        return r;
    endfunction

    task automatic xfer(input logic rw, input logic [6:0] a, input logic [3:0] be, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output logic upd);
        bus_if.bus_address = a; bus_if.bus_byte_enable = be; bus_if.bus_rw = rw;
        bus_if.bus_write_data = d; bus_if.bus_enable = 1'b1;
        lat = 0;
        do begin tick(); lat++; end while (!bus_if.bus_acknowledge && lat <= 20);
        rd = bus_if.bus_read_data; upd = setpoint_update;
        bus_if.bus_enable = 1'b0;
        tick(); tick();
    endtask

    task automatic wr_m(input logic [6:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] rdv; int lat; logic upd, exp_upd;
        exp_upd = (a[6:2] == 5'd3) && be[0] && d[0];
        xfer(1'b0, a, be, d, rdv, lat, upd);
        m_write(a, be, d);
        check("wr_ack_latency", 64'(lat), 64'd2);
        check("setpoint_update", 64'(upd), 64'(exp_upd));
        check("coil_setpoint", coil_setpoint, exp_sp());
        check("coil_enable", 64'(coil_enable), 64'(m_enable));
        check("bus_irq", 64'(bus_if.bus_irq), 64'(m_irq_en & |m_pend));
    endtask

    task automatic rd_m(input logic [6:0] a, output logic [31:0] rdv);
        int lat; logic upd;
        xfer(1'b1, a, 4'h0, 32'd0, rdv, lat, upd);
        check("rd_ack_latency", 64'(lat), 64'd2);
        check($sformatf("read_word%0d", a[6:2]), 64'(rdv), 64'(m_read(a)));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rdv;
        int          acks, n, op, lat;
        logic        upd, saw_upd;

        reset_n = 1'b0; coil_fault = '0; coil_current = '0;
        bus_if.bus_address = '0; bus_if.bus_enable = 1'b0; bus_if.bus_byte_enable = '0;
        bus_if.bus_rw = 1'b0; bus_if.bus_write_data = '0;
        m_reset();
        repeat (3) tick();
        check("rst_ack", 64'(bus_if.bus_acknowledge), 64'd0);
        check("rst_read_data", 64'(bus_if.bus_read_data), 64'd0);
        check("rst_irq", 64'(bus_if.bus_irq), 64'd0);
        check("rst_coil_setpoint", coil_setpoint, 64'd0);
        check("rst_coil_enable", 64'(coil_enable), 64'd0);
        check("rst_setpoint_update", 64'(setpoint_update), 64'd0);
        reset_n = 1'b1;
        tick();

        // current readback, 2-cycle ack
        coil_current[15:0] = 16'h1234;
        rd_m(7'h40, rdv);
        check("current0_const", 64'(rdv), 64'h1234);

        // byte-lane shadow writes
        wr_m(7'h20, 4'b0001, 32'h0000_00AB);
        wr_m(7'h20, 4'b0010, 32'h0000_CD00);
        rd_m(7'h20, rdv);
        check("shadow0_const", 64'(rdv), 64'hCDAB);
        rd_m(7'h04, rdv);
        check("status_dirty_const", 64'(rdv), 64'h2);
        check("setpoint_unchanged", coil_setpoint, 64'd0);

        // fault interrupt, set beats coincident w1c
        wr_m(7'h00, 4'h1, 32'h2);
        coil_fault = 4'b0100; tick(); coil_fault = '0; tick();
        m_pend = m_pend | 4'b0100;
        check("irq_after_fault", 64'(bus_if.bus_irq), 64'd1);
        rd_m(7'h08, rdv);
        check("pend_const", 64'(rdv), 64'h4);
        bus_if.bus_address = 7'h08; bus_if.bus_byte_enable = 4'h1; bus_if.bus_rw = 1'b0;
        bus_if.bus_write_data = 32'h4; bus_if.bus_enable = 1'b1;
        tick();
        coil_fault = 4'b0100;
        tick();
        check("coincident_ack", 64'(bus_if.bus_acknowledge), 64'd1);
        bus_if.bus_enable = 1'b0; coil_fault = '0;
        tick(); tick();
        rd_m(7'h08, rdv);
        check("pend_set_wins", 64'(rdv), 64'h4);
        wr_m(7'h08, 4'h1, 32'h4);
        rd_m(7'h08, rdv);
        check("pend_cleared", 64'(rdv), 64'h0);
        check("irq_cleared", 64'(bus_if.bus_irq), 64'd0);

        // enable and commit
        wr_m(7'h00, 4'h1, 32'h3);
        wr_m(7'h0C, 4'h1, 32'h1);
        check("setpoint_update_one_pulse", 64'(setpoint_update), 64'd0);
        check("coil_sp0_const", 64'(coil_setpoint[15:0]), 64'hCDAB);
        rd_m(7'h04, rdv);
        check("status_clean_const", 64'(rdv), 64'h0);

        // held enable gives a single transfer
        bus_if.bus_address = 7'h40; bus_if.bus_rw = 1'b1; bus_if.bus_enable = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (bus_if.bus_acknowledge) acks++; end
        bus_if.bus_enable = 1'b0; tick(); tick();
        check("held_enable_acks", 64'(acks), 64'd1);

        // reset while in ACCESS aborts the transfer
        bus_if.bus_address = 7'h40; bus_if.bus_rw = 1'b1; bus_if.bus_enable = 1'b1;
        tick();
        reset_n = 1'b0; bus_if.bus_enable = 1'b0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (bus_if.bus_acknowledge) acks++; end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); if (bus_if.bus_acknowledge) acks++; end
        m_reset();
        check("aborted_acks", 64'(acks), 64'd0);
        check("abort_coil_enable", 64'(coil_enable), 64'd0);
        check("abort_coil_setpoint", coil_setpoint, 64'd0);
        check("abort_read_data", 64'(bus_if.bus_read_data), 64'd0);

        // randomized traffic
`ifdef CURRCTRL_WDOG_EN
        wr_m(7'h00, 4'h1, 32'h0);
`else
        wr_m(7'h00, 4'h1, 32'h1);
`endif
        for (int i = 0; i < 40; i++) begin
            coil_current = {$urandom, $urandom};
            op = int'($urandom_range(0, 4));
            case (op)
                0, 1: wr_m(7'((8 + $urandom_range(0, N-1)) << 2), 4'($urandom_range(0, 15)), $urandom);
                2:    wr_m(7'h0C, 4'($urandom_range(0, 15)), $urandom);
                3:    rd_m(7'($urandom_range(0, 31) << 2), rdv);
                default: wr_m(7'(($urandom_range(0, 1) ? 16 : 5) << 2), 4'hF, $urandom);
            endcase
        end

        // soft clear keeps enable
        wr_m(7'h00, 4'h1, 32'h5);
        rd_m(7'h20, rdv);
        check("soft_clear_shadow", 64'(rdv), 64'h0);
        check("soft_clear_setpoint", coil_setpoint, 64'd0);

`ifdef CURRCTRL_WDOG_EN
        wr_m(7'h20, 4'h3, 32'h1111);
        wr_m(7'h0C, 4'h1, 32'h1);
        n = 0; saw_upd = 1'b0;
        while (coil_setpoint[15:0] !== 16'h0 && n < 200) begin
            tick(); n++;
            if (setpoint_update) saw_upd = 1'b1;
        end
        for (int k = 0; k < N; k++) m_active[k] = '0;
        check("wdog_trip_window", 64'(n >= 90 && n <= 100), 64'd1);
        check("wdog_no_update", 64'(saw_upd), 64'd0);
        check("wdog_irq", 64'(bus_if.bus_irq), 64'd1);
        xfer(1'b1, 7'h04, 4'h0, 32'd0, rdv, lat, upd);
        check("wdog_status", 64'(rdv), 64'h1);
        wr_m(7'h00, 4'h1, 32'h5);
        xfer(1'b1, 7'h04, 4'h0, 32'd0, rdv, lat, upd);
        check("wdog_cleared", 64'(rdv), 64'h0);
        wr_m(7'h00, 4'h1, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
